uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
8N1 UART receiver. It is the receive-side counterpart of the sensor hub's uart_tx and uses the same CLK_FREQ/BAUD parameterisation, so a loopback of uart_tx.tx into uart_rx.rx runs at matching bit timing. It synchronises the asynchronous serial line, validates the start bit at mid-bit, samples 8 data bits LSB-first at bit centres and checks the stop bit. Each completed byte is presented with a one-cycle valid pulse for the host/command path.

Parameters:
CLK_FREQ, 1_000_000, system clock frequency in Hz.
BAUD, 9600, serial bit rate.
CLKS_PER_BIT, CLK_FREQ/BAUD (integer division; 104 at defaults), clocks per bit. Derived localparam, not overridable.
HALF_BIT, CLKS_PER_BIT/2 (52 at defaults), clocks from start-bit detection to mid-start sampling. Derived localparam.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
rx  input  1  serial line. Idle high; asynchronous to clk.
rx_data  output  8  last correctly framed byte. Holds its value until the next good frame.
rx_valid  output  1  one-cycle pulse: rx_data updated this cycle.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
rx_busy  output  1  high whenever the FSM is outside IDLE.

Behaviour:
Reset values (asynchronous on rst_n=0):
- Both synchroniser flops = 1.
- state = IDLE.
- Bit counter = 0, clock counter = 0.
- Shift register = 0x00, rx_data = 0x00.
- rx_valid, frame_err, rx_busy = 0.

Synchroniser and sampling:
- rx passes through a 2-flop synchroniser. rx_s is the second flop.
- All decisions use rx_s only.
- Clock counter width is clog2(CLKS_PER_BIT). It is cleared on every state change.

FSM states and transitions:
- IDLE: if rx_s==0, go to START and clear the counter.
- START: count to HALF_BIT-1, then sample.
  - rx_s==0: go to DATA, clear the counter, bit index = 0.
  - rx_s==1: glitch/false start; return to IDLE with no output pulse.
- DATA: count to CLKS_PER_BIT-1, then sample.
  - Shift right with rx_s inserted at bit 7, giving LSB-first order.
  - Increment bit index. After index 7 is sampled, go to STOP.
- STOP: count to CLKS_PER_BIT-1, then sample.
  - rx_s==1: rx_data <= shift register, rx_valid=1 for exactly one cycle, go to IDLE.
  - rx_s==0: frame_err=1 for one cycle, rx_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break condition (line held low) from being re-detected as a start bit.

Timing and flags:
- Latency: rx_valid asserts 2 + HALF_BIT + 9*CLKS_PER_BIT cycles (±1) after the falling edge of the start bit on rx. At defaults that is about 990 cycles, i.e. the middle of the stop bit.
- Back-to-back frames: returning to IDLE at mid-stop leaves half a bit of margin, so a start bit immediately following the stop bit is detected. Frames are accepted with zero idle gap.
- rx_busy = (state != IDLE). It is registered, so it rises one cycle after rx_s falls.
- rx_valid and frame_err are never high in the same cycle.
- No handshake or backpressure: the consumer must capture rx_data on the rx_valid pulse. An overwritten byte is not flagged.
- Reset mid-frame: everything returns to reset values immediately and no pulse is generated. After rst_n deasserts, a line already low is treated as a start bit; only a clean frame produces rx_valid.
- No parity. Only 8 data bits and 1 stop bit are supported.

Decomposition:
Shared package uart_pkg:
- UART_DATA_BITS = 8.
- State enum: IDLE, START, DATA, STOP, WAIT_HIGH.
- Helper function clks_per_bit(CLK_FREQ, BAUD), also used by uart_tx.

One natural sub-module: sync_2ff, a generic 2-flop synchroniser with parameterised reset value (set to 1 here). The remainder stays flat in uart_rx.

Test Plan:
1. Loopback uart_tx→uart_rx at defaults, send 0x55 then 0xA3 → rx_valid pulses exactly twice, rx_data=0x55 then 0xA3, frame_err never asserted.
2. Back-to-back frames 0x00, 0xFF, 0x81 with zero idle gap (bench-driven rx) → three rx_valid pulses with the correct bytes, each ~990 cycles after its start edge.
3. Glitch: rx low for 20 clocks (< HALF_BIT=52) → return to IDLE; no rx_valid, no frame_err; rx_busy high for about 52 cycles only.
4. Frame 0x3C with stop bit forced low, then line held low for 3 bit times → one frame_err pulse, no rx_valid, rx_data keeps its prior value, FSM stays in WAIT_HIGH until the line goes high. A following clean 0x3C is received correctly.
5. rst_n pulsed low during bit 4 of 0xC6 → all outputs reset immediately, no pulse. The next clean 0x5A is received as 0x5A.
6. Baud tolerance: bench bit period at CLKS_PER_BIT ±3% for 0xA5 → rx_data=0xA5 with no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, receiver state encoding and the
// bit-timing helper used by both the transmitter and the receiver.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } uart_state_e;

   // Integer clocks per serial bit; shared with uart_tx so both ends agree.
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level.
// RST_VAL sets both flops on reset so the output starts at the line's idle level.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Start bit is re-checked at mid-bit, data bits are
// sampled at bit centres LSB-first, and the stop bit is checked at its centre.
// Returning to IDLE at mid-stop leaves half a bit of margin, so frames with
// zero idle gap are accepted.
//
//   state     | meaning
//   IDLE      | line idle, waiting for rx_s low
//   START     | half-bit wait, then confirm start bit still low
//   DATA      | sample 8 data bits at bit centres
//   STOP      | sample stop bit; publish byte or flag framing error
//   WAIT_HIGH | after a framing error, wait for line to return high
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 1_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic                      rx_s;
   uart_state_e               state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [2:0]                bit_idx_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [UART_DATA_BITS-1:0] rx_data_q;
   logic                      rx_valid_q;
   logic                      frame_err_q;
   logic                      rx_busy_q;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync_rx (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   // Receive FSM with bit/clock counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         rx_busy_q   <= 1'b0;
      end else begin
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (!rx_s) begin
                  state_q   <= START;
                  rx_busy_q <= 1'b1;
               end
            end
            START: begin
               if (cnt_q == HALF_M1) begin
                  cnt_q <= '0;
                  if (!rx_s) begin
                     state_q   <= DATA;
                     bit_idx_q <= '0;
                  end else begin
                     // Line went back high before mid-start: treat as a glitch.
                     state_q   <= IDLE;
                     rx_busy_q <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            DATA: begin
               if (cnt_q == BIT_M1) begin
                  cnt_q     <= '0;
                  shift_q   <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            STOP: begin
               if (cnt_q == BIT_M1) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     rx_data_q  <= shift_q;
                     rx_valid_q <= 1'b1;
                     state_q    <= IDLE;
                     rx_busy_q  <= 1'b0;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= WAIT_HIGH;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            WAIT_HIGH: begin
               // A held-low line (break) must not be mistaken for a new start bit.
               cnt_q <= '0;
               if (rx_s) begin
                  state_q   <= IDLE;
                  rx_busy_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               cnt_q     <= '0;
               rx_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of single frames plus hand-written
// sequences for back-to-back frames, glitches, breaks and mid-frame reset.
module tb_uart_rx;

   localparam int CPB = 104;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_busy;

   uart_rx #(
      .CLK_FREQ (1_000_000),
      .BAUD     (9600)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [7:0] vq[$];
   int         vcyc[$];
   int         starts[$];
   int         ferr_cnt = 0;
   int         both_cnt = 0;
   int         busy_cnt = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) begin
            vq.push_back(rx_data);
            vcyc.push_back(cyc);
         end
         if (frame_err) ferr_cnt++;
         if (rx_valid && frame_err) both_cnt++;
         if (rx_busy) busy_cnt++;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one 8N1 frame; rst_slot >= 0 asserts reset in the middle of that slot.
   task automatic send_frame(input logic [7:0] d, input logic stop_b, input int period,
                             input int rst_slot);
      logic [9:0] bits;
      bits = {stop_b, d, 1'b0};
      starts.push_back(cyc);
      for (int s = 0; s < 10; s++) begin
         rx = bits[s];
         if (s == rst_slot) begin
            idle(period / 2);
            rst_n = 1'b0;
            #1;
            check("rst_data",  int'(rx_data),   0);
            check("rst_valid", int'(rx_valid),  0);
            check("rst_ferr",  int'(frame_err), 0);
            check("rst_busy",  int'(rx_busy),   0);
            idle(period - period / 2);
         end else begin
            idle(period);
         end
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop_b;
      int         period;
      int         exp_valid;
      logic [7:0] exp_data;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int v0, f0, b0, s0;
      rx    = 1'b1;
      rst_n = 1'b0;

      vecs[0] = '{8'h55, 1'b1, CPB,     1, 8'h55, 0};
      vecs[1] = '{8'hA3, 1'b1, CPB,     1, 8'hA3, 0};
      vecs[2] = '{8'hA5, 1'b1, CPB + 3, 1, 8'hA5, 0};
      vecs[3] = '{8'h0F, 1'b1, CPB - 3, 1, 8'h0F, 0};
      vecs[4] = '{8'h3C, 1'b0, CPB,     0, 8'h0F, 1};
      vecs[5] = '{8'hC3, 1'b1, CPB,     1, 8'hC3, 0};

      idle(3);
      #1;
      check("reset_data",  int'(rx_data),   0);
      check("reset_valid", int'(rx_valid),  0);
      check("reset_ferr",  int'(frame_err), 0);
      check("reset_busy",  int'(rx_busy),   0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(10);

      // Single frames, nominal and off-baud, one with a bad stop bit.
      for (int i = 0; i < 6; i++) begin
         v0 = vq.size();
         f0 = ferr_cnt;
         s0 = starts.size();
         send_frame(vecs[i].data, vecs[i].stop_b, vecs[i].period, -1);
         rx = 1'b1;
         idle(2 * CPB);
         check($sformatf("vec%0d_valid_cnt", i), vq.size() - v0, vecs[i].exp_valid);
         check($sformatf("vec%0d_data", i), int'(rx_data), int'(vecs[i].exp_data));
         check($sformatf("vec%0d_ferr_cnt", i), ferr_cnt - f0, vecs[i].exp_ferr);
         if (vecs[i].exp_valid == 1 && vq.size() > v0)
            check_range($sformatf("vec%0d_latency", i), vcyc[v0] - starts[s0], 989, 992);
      end

      // Back-to-back frames with no idle gap.
      v0 = vq.size();
      f0 = ferr_cnt;
      s0 = starts.size();
      send_frame(8'h00, 1'b1, CPB, -1);
      send_frame(8'hFF, 1'b1, CPB, -1);
      send_frame(8'h81, 1'b1, CPB, -1);
      rx = 1'b1;
      idle(2 * CPB);
      check("b2b_valid_cnt", vq.size() - v0, 3);
      check("b2b_ferr_cnt", ferr_cnt - f0, 0);
      if (vq.size() >= v0 + 3) begin
         check("b2b_data0", int'(vq[v0]),     8'h00);
         check("b2b_data1", int'(vq[v0 + 1]), 8'hFF);
         check("b2b_data2", int'(vq[v0 + 2]), 8'h81);
         for (int k = 0; k < 3; k++)
            check_range($sformatf("b2b_latency%0d", k), vcyc[v0 + k] - starts[s0 + k], 989, 992);
      end

      // Short low glitch shorter than half a bit.
      v0 = vq.size();
      f0 = ferr_cnt;
      b0 = busy_cnt;
      rx = 1'b0;
      idle(20);
      rx = 1'b1;
      idle(2 * CPB);
      check("glitch_valid_cnt", vq.size() - v0, 0);
      check("glitch_ferr_cnt", ferr_cnt - f0, 0);
      check_range("glitch_busy_cycles", busy_cnt - b0, 50, 54);

      // Bad stop bit followed by a break lasting three bit times.
      v0 = vq.size();
      f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0, CPB, -1);
      idle(3 * CPB);
      check("break_ferr_cnt", ferr_cnt - f0, 1);
      check("break_valid_cnt", vq.size() - v0, 0);
      check("break_data_kept", int'(rx_data), 8'h81);
      check("break_busy_held", int'(rx_busy), 1);
      rx = 1'b1;
      idle(5);
      check("break_busy_release", int'(rx_busy), 0);
      idle(CPB);
      v0 = vq.size();
      send_frame(8'h3C, 1'b1, CPB, -1);
      idle(2 * CPB);
      check("after_break_valid_cnt", vq.size() - v0, 1);
      check("after_break_data", int'(rx_data), 8'h3C);

      // Reset asserted during data bit 4 and held until the frame ends.
      v0 = vq.size();
      f0 = ferr_cnt;
      send_frame(8'hC6, 1'b1, CPB, 5);
      rx = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      idle(2 * CPB);
      check("rst_valid_cnt", vq.size() - v0, 0);
      check("rst_ferr_cnt", ferr_cnt - f0, 0);
      v0 = vq.size();
      send_frame(8'h5A, 1'b1, CPB, -1);
      idle(2 * CPB);
      check("after_rst_valid_cnt", vq.size() - v0, 1);
      check("after_rst_data", int'(rx_data), 8'h5A);

      check("valid_ferr_overlap", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
